// File: rtl/prot_seq_trig.sv
// Multi-word protocol sequence trigger: qualifies decoded SPI/UART words against per-stage mask/match.
// Optional inter-word timeout built when PROT_SEQ_TIMEOUT_EN is defined.
module prot_seq_trig #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TO_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     arm,
    input  logic                     src_sel,
    input  logic                     trig_dis,
    input  logic                     spi_vld,
    input  logic [WIDTH-1:0]         spi_data,
    input  logic                     uart_vld,
    input  logic [7:0]               uart_data,
    input  logic [$clog2(DEPTH):0]   seq_len,
    input  logic [DEPTH*WIDTH-1:0]   mask,
    input  logic [DEPTH*WIDTH-1:0]   match,
    input  logic [TO_W-1:0]          timeout,
    output logic [$clog2(DEPTH):0]   stage,
    output logic                     protTrig
);

    localparam int unsigned SW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {IDLE, HUNT, TRIG} state_t;

    state_t              state;
    logic                wordVld;
    logic [WIDTH-1:0]    word;
    logic [SW-1:0]       effLast;
    logic [SW-1:0]       evalStage;
    logic [(1<<SW)-1:0]  hitVec;
    logic                curHit;
    logic                expired;

    // Selected word source; UART bytes are zero-extended.
    assign wordVld = src_sel ? uart_vld : spi_vld;
    assign word    = src_sel ? WIDTH'(uart_data) : spi_data;

    // Index of the final stage after clamping seq_len into 1..DEPTH.
    always_comb begin
        effLast = '0;
        if (seq_len == '0)
            effLast = '0;
        else if (seq_len > SW'(DEPTH))
            effLast = SW'(DEPTH - 1);
        else
            effLast = seq_len - SW'(1);
    end

    // Per-stage hit flags; vector is padded to a power of two so any stage value indexes safely.
    always_comb begin
        hitVec = '0;
        for (int k = 0; k < int'(DEPTH); k++)
            hitVec[k] = ((word ^ match[k*WIDTH +: WIDTH]) & ~mask[k*WIDTH +: WIDTH]) == '0;
    end

    assign evalStage = expired ? '0 : stage;
    assign curHit    = hitVec[evalStage];

`ifdef PROT_SEQ_TIMEOUT_EN
    logic [TO_W-1:0] timer;

    assign expired = (state == HUNT) && (stage != '0) && (timeout != '0) && (timer == timeout);

    // Idle-cycle counter between accepted words; saturates instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            timer <= '0;
        else if (!arm || state != HUNT || stage == '0 || wordVld || expired || timeout == '0)
            timer <= '0;
        else if (timer != '1)
            timer <= timer + TO_W'(1);
    end
`else
    logic unusedTimeout;

    assign expired       = 1'b0;
    assign unusedTimeout = ^timeout;
`endif

    // Sequencer state, stage index and trigger output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            stage    <= '0;
            protTrig <= 1'b0;
        end else if (!arm) begin
            state    <= IDLE;
            stage    <= '0;
            protTrig <= 1'b0;
        end else begin
            protTrig <= trig_dis;
            case (state)
                IDLE: begin
                    state <= HUNT;
                    stage <= '0;
                end
                HUNT: begin
                    if (wordVld) begin
                        if (curHit && evalStage >= effLast) begin
                            state    <= TRIG;
                            stage    <= effLast;
                            protTrig <= 1'b1;
                        end else if (curHit) begin
                            stage <= evalStage + SW'(1);
                        end else if (hitVec[0] && effLast == '0) begin
                            state    <= TRIG;
                            stage    <= effLast;
                            protTrig <= 1'b1;
                        end else if (hitVec[0]) begin
                            stage <= SW'(1);
                        end else begin
                            stage <= '0;
                        end
                    end else if (expired) begin
                        stage <= '0;
                    end
                end
                TRIG: begin
                    stage    <= effLast;
                    protTrig <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    stage <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prot_seq_trig.sv
// Randomised and directed bench for prot_seq_trig against a prefix-count reference model.
module tb_prot_seq_trig;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TO_W  = 16;
    localparam int unsigned SW    = $clog2(DEPTH) + 1;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   arm;
    logic                   srcSel;
    logic                   trigDis;
    logic                   spiVld;
    logic [WIDTH-1:0]       spiData;
    logic                   uartVld;
    logic [7:0]             uartData;
    logic [SW-1:0]          seqLen;
    logic [DEPTH*WIDTH-1:0] mask;
    logic [DEPTH*WIDTH-1:0] match;
    logic [TO_W-1:0]        timeout;
    logic [SW-1:0]          stage;
    logic                   protTrig;

    int testCnt = 0;
    int failCnt = 0;

    // Model: 0 idle, 1 hunting, 2 triggered; mPos is the matched-prefix length so far.
    int mMode = 0;
    int mPos  = 0;
    int mIdle = 0;
    bit mTrig = 1'b0;

    prot_seq_trig #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TO_W(TO_W)) dut (
        .clk(clk), .rst(rst), .arm(arm), .src_sel(srcSel), .trig_dis(trigDis),
        .spi_vld(spiVld), .spi_data(spiData), .uart_vld(uartVld), .uart_data(uartData),
        .seq_len(seqLen), .mask(mask), .match(match), .timeout(timeout),
        .stage(stage), .protTrig(protTrig)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testCnt++;
        if (got !== exp) begin
            failCnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int effLen();
        int n = int'(seqLen);
        if (n == 0) return 1;
        if (n > int'(DEPTH)) return int'(DEPTH);
        return n;
    endfunction

    function automatic bit hitAt(input int k, input logic [WIDTH-1:0] w);
        return ((w ^ match[k*WIDTH +: WIDTH]) & ~mask[k*WIDTH +: WIDTH]) == '0;
    endfunction

    function automatic void modelReset();
        mMode = 0; mPos = 0; mIdle = 0; mTrig = 1'b0;
    endfunction

    // One clock of the reference behaviour, using the inputs present during that cycle.
    function automatic void modelStep();
        int L = effLen();
        bit v = srcSel ? uartVld : spiVld;
        logic [WIDTH-1:0] w = srcSel ? {8'h00, uartData} : spiData;
        bit late = 1'b0;
        int cur;
        int nxt;
        if (!arm) begin
            modelReset();
            return;
        end
        if (mMode == 0) begin
            mMode = 1; mPos = 0; mIdle = 0; mTrig = trigDis;
            return;
        end
        if (mMode == 2) begin
            mPos = L - 1; mTrig = 1'b1;
            return;
        end
`ifdef PROT_SEQ_TIMEOUT_EN
        late = (mPos > 0) && (timeout != '0) && (mIdle == int'(timeout));
`endif
        cur   = late ? 0 : mPos;
        mTrig = trigDis;
        if (v) begin
            mIdle = 0;
            if (hitAt(cur, w))    nxt = cur + 1;
            else if (hitAt(0, w)) nxt = 1;
            else                  nxt = 0;
            if (nxt >= L) begin
                mMode = 2; mPos = L - 1; mTrig = 1'b1;
            end else begin
                mPos = nxt;
            end
        end else if (late) begin
            mPos = 0; mIdle = 0;
        end else if (mPos > 0 && timeout != '0 && mIdle < (1 << TO_W) - 1) begin
            mIdle++;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkVal("stage", 32'(stage), 32'(mPos));
        checkVal("protTrig", 32'(protTrig), 32'(mTrig));
        spiVld  = 1'b0;
        uartVld = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic sendSpi(input logic [WIDTH-1:0] w);
        spiVld = 1'b1; spiData = w;
        tick();
    endtask

    task automatic sendUart(input logic [7:0] b);
        uartVld = 1'b1; uartData = b;
        tick();
    endtask

    task automatic rearm();
        arm = 1'b0; tick();
        arm = 1'b1; tick();
    endtask

    task automatic cfgSeq3();
        srcSel = 1'b0; seqLen = SW'(3); mask = '0; timeout = '0;
        match  = {16'h0000, 16'hFFFF, 16'h1234, 16'hA5A5};
    endtask

    task automatic randCfg();
        seqLen  = SW'($urandom_range(0, 5));
        srcSel  = 1'($urandom_range(0, 1));
        timeout = TO_W'($urandom_range(0, 8));
        for (int k = 0; k < int'(DEPTH); k++) begin
            match[k*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 255));
            mask[k*WIDTH +: WIDTH]  = WIDTH'($urandom & $urandom & 32'h0000_00FF);
        end
    endtask

    initial begin
        int k;
        rst = 1'b1; arm = 1'b0; trigDis = 1'b0; spiVld = 1'b0; uartVld = 1'b0;
        spiData = '0; uartData = '0; cfgSeq3();
        modelReset();
        @(negedge clk); @(negedge clk);
        checkVal("rst_stage", 32'(stage), 32'd0);
        checkVal("rst_trig", 32'(protTrig), 32'd0);
        rst = 1'b0;

        // Basic three-word sequence; a word on the first armed cycle is ignored.
        arm = 1'b1; spiVld = 1'b1; spiData = 16'hA5A5; tick();
        checkVal("t1_first_arm", 32'(stage), 32'd0);
        sendSpi(16'hA5A5); checkVal("t1_s1", 32'(stage), 32'd1);
        sendSpi(16'h1234); checkVal("t1_s2", 32'(stage), 32'd2);
        sendSpi(16'hFFFF); checkVal("t1_trig", 32'(protTrig), 32'd1);
        idle(2);
        checkVal("t1_sticky", 32'(protTrig), 32'd1);

        // Repeated first word re-hits stage 0.
        rearm();
        sendSpi(16'hA5A5); checkVal("t2_s1", 32'(stage), 32'd1);
        sendSpi(16'hA5A5); checkVal("t2_s1b", 32'(stage), 32'd1);
        sendSpi(16'h1234); checkVal("t2_s2", 32'(stage), 32'd2);
        sendSpi(16'hFFFF); checkVal("t2_trig", 32'(protTrig), 32'd1);

        // UART single-stage with masked nibble.
        arm = 1'b0; tick();
        srcSel = 1'b1; seqLen = SW'(1); match[15:0] = 16'h0041; mask[15:0] = 16'h00F0;
        arm = 1'b1; tick();
        sendUart(8'h51); checkVal("t3_hit", 32'(protTrig), 32'd1);
        rearm();
        sendUart(8'h52); checkVal("t3_miss", 32'(protTrig), 32'd0);

        // Inter-word gap: 10 idle cycles expires when the timeout is built.
        arm = 1'b0; tick();
        cfgSeq3(); timeout = TO_W'(10);
        arm = 1'b1; tick();
        sendSpi(16'hA5A5); idle(10); sendSpi(16'h1234);
`ifdef PROT_SEQ_TIMEOUT_EN
        checkVal("t4_expired", 32'(stage), 32'd0);
`else
        checkVal("t4_no_timer", 32'(stage), 32'd2);
`endif
        rearm();
        sendSpi(16'hA5A5); idle(8); sendSpi(16'h1234);
        checkVal("t4_in_time", 32'(stage), 32'd2);

        // Trigger disable, arm drop and asynchronous reset from TRIG.
        arm = 1'b0; tick();
        trigDis = 1'b1; arm = 1'b1; idle(2);
        checkVal("t5_dis", 32'(protTrig), 32'd1);
        arm = 1'b0; tick();
        checkVal("t5_drop", 32'(protTrig), 32'd0);
        trigDis = 1'b0; timeout = '0; arm = 1'b1; tick();
        sendSpi(16'hA5A5); sendSpi(16'h1234); sendSpi(16'hFFFF);
        checkVal("t5_intrig", 32'(protTrig), 32'd1);
        #2 rst = 1'b1;
        #1 checkVal("t5_async_trig", 32'(protTrig), 32'd0);
        checkVal("t5_async_stage", 32'(stage), 32'd0);
        modelReset();
        arm = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Simultaneous strobes: only the selected source counts.
        srcSel = 1'b0; seqLen = SW'(2); mask = '0;
        match[15:0] = 16'h0033; match[31:16] = 16'h0044;
        arm = 1'b1; tick();
        spiVld = 1'b1; spiData = 16'h0033; uartVld = 1'b1; uartData = 8'h55; tick();
        checkVal("t6_spi_hit", 32'(stage), 32'd1);
        spiVld = 1'b1; spiData = 16'h0000; uartVld = 1'b1; uartData = 8'h44; tick();
        checkVal("t6_uart_ignored", 32'(stage), 32'd0);

        // Random traffic checked cycle by cycle against the model.
        arm = 1'b0; tick();
        for (int i = 0; i < 3000; i++) begin
            if (!arm) begin
                if ($urandom_range(0, 3) == 0) begin
                    randCfg();
                    arm = 1'b1;
                end
            end else if ($urandom_range(0, 60) == 0) begin
                arm = 1'b0;
            end
            trigDis = ($urandom_range(0, 15) == 0);
            spiVld  = ($urandom_range(0, 2) == 0);
            uartVld = ($urandom_range(0, 2) == 0);
            k = int'($urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 3) != 0) begin
                spiData  = match[k*WIDTH +: WIDTH] ^ (WIDTH'($urandom) & mask[k*WIDTH +: WIDTH]);
                uartData = 8'(match[k*WIDTH +: WIDTH] ^ (WIDTH'($urandom) & mask[k*WIDTH +: WIDTH]));
            end else begin
                spiData  = WIDTH'($urandom);
                uartData = 8'($urandom);
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
        $finish;
    end

endmodule

// File: doc/prot_seq_trig.md
# prot_seq_trig

Parametrised multi-word protocol trigger for the logic analyzer capture path. Consumes decoded words from the SPI and UART receivers and qualifies each word per stage with mask/match (mask bit 1 = don't care). Asserts `protTrig` only when a programmed sequence of up to DEPTH consecutive words matches, with an optional inter-word timeout. Output feeds the trigger-combine logic in place of the single-word protocol trigger.

## Interface
- WIDTH, 16: word width compared per stage (8..32).
- DEPTH, 4: number of sequence stages (1..8).
- TO_W, 16: timeout counter width.

- clk  in  1  system clock.
- rst  in  1  reset; one clock; asynchronous, active-high.
- arm  in  1  level; low holds block idle and clears trigger.
- src_sel  in  1  word source: 0 SPI, 1 UART.
- trig_dis  in  1  protocol trigger don't-care; forces `protTrig` high while armed.
- spi_vld  in  1  single-cycle strobe, `spi_data` valid.
- spi_data  in  WIDTH  SPI word; 8-bit SPI transfers arrive zero-extended.
- uart_vld  in  1  single-cycle strobe, `uart_data` valid.
- uart_data  in  8  UART byte, zero-extended to WIDTH before compare.
- seq_len  in  $clog2(DEPTH)+1  stages used; 0 treated as 1, values >DEPTH treated as DEPTH.
- mask  in  DEPTH*WIDTH  stage k mask at [k*WIDTH +: WIDTH].
- match  in  DEPTH*WIDTH  stage k match at [k*WIDTH +: WIDTH].
- timeout  in  TO_W  max idle cycles between words; 0 = no timeout.
- stage  out  $clog2(DEPTH)+1  current stage index (registered).
- protTrig  out  1  protocol trigger (registered).

## Operation
- Word hit for stage k: ((word ^ match_k) & ~mask_k) == 0.
- Only the source chosen by `src_sel` is observed; the other strobe is ignored, including when both strobe together.
- States: IDLE, HUNT, TRIG.
- IDLE: `stage`=0, `protTrig`=0. `arm`=1 -> HUNT next cycle. Words during IDLE, including the first `arm`-high cycle, are ignored.
- HUNT, word at stage s: hit on s with s==L-1 (L = effective seq_len) -> TRIG. Hit on s<L-1 -> stage s+1, timer cleared. Miss: re-evaluate against stage 0; hit -> stage 1, or TRIG when L==1. Otherwise stage 0.
- TRIG: sticky; `protTrig`=1, `stage` holds L-1, words ignored.
- Any state, `arm`=0 -> IDLE next cycle.
- `protTrig` = (state==TRIG) | (armed & trig_dis), registered. `trig_dis` does not stop sequencer operation.
- Timeout: with stage>0 and timeout!=0, timer counts cycles with no accepted word. When timer == timeout, stage returns to 0. On the expiry cycle a strobed word is evaluated against stage 0 only. Timer saturates and never wraps.
- `seq_len`, `mask`, `match`, `src_sel` and `timeout` change only while `arm`=0. Changes while armed take effect immediately, with no restart.

## Timing
- Reset: state IDLE, `stage`=0, `protTrig`=0, timer=0.
- Latency: `protTrig` rises on the clock edge after the cycle in which the final matching strobe is high (1 cycle).
- `stage` updates on the edge after each strobe.
- `arm` fall -> `protTrig` low 1 cycle later.
- Back-to-back strobes on consecutive cycles are fully supported, one word per cycle.
- Reset mid-sequence aborts immediately (asynchronous).

## Configuration
- PROT_SEQ_TIMEOUT_EN defined: timeout counter built, behaviour as above.
- PROT_SEQ_TIMEOUT_EN undefined: no counter; `timeout` port present but ignored; the sequence waits indefinitely between words.

## Test plan
- WIDTH=16, DEPTH=4, SPI, L=3, match 0xA5A5/0x1234/0xFFFF, mask 0, words A5A5,1234,FFFF -> `stage` 1,2, then `protTrig`=1 one cycle after the third strobe.
- Same config, words A5A5,A5A5,1234,FFFF -> stage 1,1 (miss re-hits stage 0),2, then trigger.
- UART, L=1, match 0x0041, mask 0x00F0, byte 0x51 -> trigger; byte 0x52 -> none.
- PROT_SEQ_TIMEOUT_EN, timeout=10, A5A5 then 1234 eleven cycles later -> stage back to 0 at cycle 10, no trigger. Repeat at 9 cycles -> stage 2.
- `trig_dis`=1, armed, no words -> `protTrig`=1. `arm` drop -> 0 next cycle. Assert `rst` while in TRIG -> outputs 0 asynchronously.
- `src_sel`=0 with uart_vld/spi_vld simultaneous carrying different words -> only the SPI word affects `stage`.
